// File: rtl/reorder_buffer_cdb.sv
// reorder_buffer_cdb
//   Reorder buffer and result sink for the Tomasulo core. Each issued instruction
//   gets one RB entry. FU results land in their entries, and completed entries are
//   rebroadcast on the CDB so reservation stations can wake up. A rename table
//   answers RS operand lookups. Entries retire in order into the architectural
//   register file.
// Ports
//   clk, reset_n              clock (posedge), asynchronous active-low reset
//   flush                     synchronous squash of every in-flight entry
//   alloc_req/alloc_dest      issue request and its destination register
//   alloc_ok/alloc_index      an entry is free / the tag it will receive
//   data_bus/valid_bus/
//   RB_index_bus              FU results: slice i belongs to FU i
//   reset_bus                 per-FU clear; all ones after reset or flush
//   reg_numj/k -> vj,qj/vk,qk operand lookups for the reservation stations
//   CDB_data_data/valid       per-entry value, and a flag for "busy and done"
//   commit_valid/reg/data     one-cycle retire pulse with its register and value
module reorder_buffer_cdb #(
  parameter int WORD_SIZE = 32,
  parameter int RB_SIZE   = 8,
  parameter int RB_INDEX  = 4,
  parameter int READY     = 14,
  parameter int NULL      = 15,
  parameter int FU_NUM    = 4,
  parameter int REG_INDEX = 5
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          flush,
  input  logic                          alloc_req,
  input  logic [REG_INDEX-1:0]          alloc_dest,
  output logic                          alloc_ok,
  output logic [RB_INDEX-1:0]           alloc_index,
  input  logic [FU_NUM*WORD_SIZE-1:0]   data_bus,
  input  logic [FU_NUM-1:0]             valid_bus,
  input  logic [FU_NUM*RB_INDEX-1:0]    RB_index_bus,
  output logic [FU_NUM-1:0]             reset_bus,
  input  logic [REG_INDEX-1:0]          reg_numj,
  input  logic [REG_INDEX-1:0]          reg_numk,
  output logic [WORD_SIZE-1:0]          vj,
  output logic [WORD_SIZE-1:0]          vk,
  output logic [RB_INDEX-1:0]           qj,
  output logic [RB_INDEX-1:0]           qk,
  output logic [WORD_SIZE*RB_SIZE-1:0]  CDB_data_data,
  output logic [RB_SIZE-1:0]            CDB_data_valid,
  output logic                          commit_valid,
  output logic [REG_INDEX-1:0]          commit_reg,
  output logic [WORD_SIZE-1:0]          commit_data
);

  localparam int REG_NUM = 2 ** REG_INDEX;
  localparam int PTR_W   = $clog2(RB_SIZE);
  localparam logic [RB_INDEX-1:0] TAG_READY = RB_INDEX'(READY);
  localparam logic [RB_INDEX-1:0] TAG_NULL  = RB_INDEX'(NULL);
  localparam logic [RB_INDEX-1:0] RB_FULL   = RB_INDEX'(RB_SIZE);

  typedef enum logic [1:0] {E_FREE, E_PENDING, E_DONE} entry_state_e;

  typedef struct packed {
    logic [WORD_SIZE-1:0] v;
    logic [RB_INDEX-1:0]  q;
  } lookup_t;

  entry_state_e         state   [RB_SIZE];
  logic [REG_INDEX-1:0] dest    [RB_SIZE];
  logic [WORD_SIZE-1:0] value   [RB_SIZE];
  logic [RB_INDEX-1:0]  rename  [REG_NUM];
  logic [WORD_SIZE-1:0] regfile [REG_NUM];
  logic [PTR_W-1:0]     head, tail;
  logic [RB_INDEX-1:0]  count;

  logic                 alloc_fire, commit_fire;
  logic [RB_SIZE-1:0]   wb_hit;
  logic [WORD_SIZE-1:0] wb_val [RB_SIZE];
  lookup_t              look_j, look_k;

  assign alloc_ok    = count < RB_FULL;
  assign alloc_index = RB_INDEX'(tail);
  assign alloc_fire  = !flush && alloc_req && alloc_ok;
  assign commit_fire = !flush && (count != '0) && (state[head] == E_DONE);

  // Writeback decode per entry. The loop walks the FUs from highest to lowest so
  // the last write is from the lowest-numbered FU, and that FU wins a shared tag.
  // Tags outside the entry range (READY, NULL, unused codes) are ignored.
  // NOTE: every output of a combinational block is assigned a default first, so
  //       no path can leave it holding a stale value and infer a latch.
  always_comb begin
    wb_hit = '0;
    for (int k = 0; k < RB_SIZE; k++) wb_val[k] = '0;
    for (int i = FU_NUM - 1; i >= 0; i--) begin
      if (valid_bus[i] && (RB_index_bus[i*RB_INDEX +: RB_INDEX] != TAG_NULL)
          && (RB_index_bus[i*RB_INDEX +: RB_INDEX] < RB_FULL)) begin
        wb_hit[RB_index_bus[i*RB_INDEX +: PTR_W]] = 1'b1;
        wb_val[RB_index_bus[i*RB_INDEX +: PTR_W]] = data_bus[i*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  // Operand lookup. An unknown register number means the RS is idle, and it reads back as NULL.
  function automatic lookup_t lookup(input logic [REG_INDEX-1:0] r);
    lookup_t res;
    logic [RB_INDEX-1:0] t;
    res.v = '0;
    res.q = TAG_READY;
    t     = rename[r];
    if ($isunknown(r)) begin
      res.q = TAG_NULL;
    end else if (r != '0) begin
      if (t == TAG_READY) res.v = regfile[r];
      else if ((t < RB_FULL) && (state[t[PTR_W-1:0]] == E_DONE)) res.v = value[t[PTR_W-1:0]];
      else res.q = t;
    end
    return res;
  endfunction

  always_comb begin
    look_j = lookup(reg_numj);
    look_k = lookup(reg_numk);
    vj = look_j.v;
    qj = look_j.q;
    vk = look_k.v;
    qk = look_k.q;
  end

  always_comb begin
    CDB_data_data  = '0;
    CDB_data_valid = '0;
    for (int k = 0; k < RB_SIZE; k++) begin
      CDB_data_data[k*WORD_SIZE +: WORD_SIZE] = value[k];
      CDB_data_valid[k] = (state[k] == E_DONE);
    end
  end

  // NOTE: the register file and rename table are reset explicitly. After reset every
  //       register must read as 0 with tag READY, so these arrays are flops and not RAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      reset_bus    <= '1;
      commit_valid <= 1'b0;
      commit_reg   <= '0;
      commit_data  <= '0;
      for (int k = 0; k < RB_SIZE; k++) begin
        state[k] <= E_FREE;
        dest[k]  <= '0;
        value[k] <= '0;
      end
      for (int r = 0; r < REG_NUM; r++) begin
        rename[r]  <= TAG_READY;
        regfile[r] <= '0;
      end
    end else if (flush) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      reset_bus    <= '1;
      commit_valid <= 1'b0;
      for (int k = 0; k < RB_SIZE; k++) state[k] <= E_FREE;
      for (int r = 0; r < REG_NUM; r++) rename[r] <= TAG_READY;
    end else begin
      reset_bus    <= '0;
      commit_valid <= commit_fire;
      commit_reg   <= '0;
      commit_data  <= '0;

      // NOTE: these are non-blocking, so each right-hand side sees pre-edge state.
      //       When two writes hit the same rename slot, the later statement wins,
      //       which lets a same-cycle alloc override the commit's clear to READY.
      if (commit_fire) begin
        commit_reg  <= dest[head];
        commit_data <= value[head];
        if (dest[head] != '0) regfile[dest[head]] <= value[head];
        if (rename[dest[head]] == RB_INDEX'(head)) rename[dest[head]] <= TAG_READY;
        head <= head + 1'b1;
      end

      if (alloc_fire) begin
        dest[tail] <= alloc_dest;
        if (alloc_dest != '0) rename[alloc_dest] <= RB_INDEX'(tail);
        tail <= tail + 1'b1;
      end

      if (alloc_fire && !commit_fire)      count <= count + 1'b1;
      else if (!alloc_fire && commit_fire) count <= count - 1'b1;

      for (int k = 0; k < RB_SIZE; k++) begin
        if (alloc_fire && (tail == PTR_W'(k))) begin
          state[k] <= E_PENDING;
        end else if (commit_fire && (head == PTR_W'(k))) begin
          state[k] <= E_FREE;
        end else if ((state[k] == E_PENDING) && wb_hit[k]) begin
          state[k] <= E_DONE;
          value[k] <= wb_val[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer_cdb.sv
// Self-checking bench for reorder_buffer_cdb: directed scenarios followed by a
// randomized run checked against an in-order queue model of the buffer.
module tb_reorder_buffer_cdb;

  localparam int WS  = 32;
  localparam int RBS = 8;
  localparam int RBI = 4;
  localparam int FUN = 4;
  localparam int RGI = 5;
  localparam logic [RBI-1:0] T_READY = 4'd14;
  localparam logic [RBI-1:0] T_NULL  = 4'd15;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               flush = 1'b0;
  logic               alloc_req = 1'b0;
  logic [RGI-1:0]     alloc_dest = '0;
  logic               alloc_ok;
  logic [RBI-1:0]     alloc_index;
  logic [FUN*WS-1:0]  data_bus = '0;
  logic [FUN-1:0]     valid_bus = '0;
  logic [FUN*RBI-1:0] RB_index_bus = '0;
  logic [FUN-1:0]     reset_bus;
  logic [RGI-1:0]     reg_numj = '0;
  logic [RGI-1:0]     reg_numk = '0;
  logic [WS-1:0]      vj, vk;
  logic [RBI-1:0]     qj, qk;
  logic [WS*RBS-1:0]  CDB_data_data;
  logic [RBS-1:0]     CDB_data_valid;
  logic               commit_valid;
  logic [RGI-1:0]     commit_reg;
  logic [WS-1:0]      commit_data;

  int vectors = 0;
  int miscompares = 0;

  reorder_buffer_cdb dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .alloc_req(alloc_req), .alloc_dest(alloc_dest),
    .alloc_ok(alloc_ok), .alloc_index(alloc_index),
    .data_bus(data_bus), .valid_bus(valid_bus), .RB_index_bus(RB_index_bus),
    .reset_bus(reset_bus),
    .reg_numj(reg_numj), .reg_numk(reg_numk),
    .vj(vj), .vk(vk), .qj(qj), .qk(qk),
    .CDB_data_data(CDB_data_data), .CDB_data_valid(CDB_data_valid),
    .commit_valid(commit_valid), .commit_reg(commit_reg), .commit_data(commit_data)
  );

  always #5 clk = ~clk;

  // Reference model: the in-flight instructions as a program-ordered queue.
  typedef struct {
    int          tag;
    logic [4:0]  dest;
    bit          done;
    logic [31:0] val;
  } ent_t;

  ent_t        rob_q[$];
  logic [31:0] rf_m [32];
  int          next_tag;
  logic        exp_cv;
  logic [4:0]  exp_creg;
  logic [31:0] exp_cdata;
  logic [3:0]  exp_rbus;

  task automatic model_reset();
    rob_q.delete();
    for (int r = 0; r < 32; r++) rf_m[r] = '0;
    next_tag  = 0;
    exp_cv    = 1'b0;
    exp_creg  = '0;
    exp_cdata = '0;
    exp_rbus  = 4'hF;
  endtask

  function automatic int find_pending(input int t);
    for (int j = 0; j < rob_q.size(); j++)
      if (rob_q[j].tag == t && !rob_q[j].done) return j;
    return -1;
  endfunction

  // A register's pending producer is the youngest in-flight instruction writing it.
  function automatic void exp_lookup(input logic [4:0] r, output logic [31:0] v,
                                     output logic [3:0] q);
    v = '0;
    q = T_READY;
    if (r == 5'd0) return;
    for (int j = rob_q.size() - 1; j >= 0; j--) begin
      if (rob_q[j].dest == r) begin
        if (rob_q[j].done) v = rob_q[j].val;
        else q = 4'(rob_q[j].tag);
        return;
      end
    end
    v = rf_m[r];
  endfunction

  function automatic void exp_cdb(input int k, output bit v, output logic [31:0] d);
    v = 1'b0;
    d = '0;
    for (int j = 0; j < rob_q.size(); j++)
      if (rob_q[j].tag == k && rob_q[j].done) begin
        v = 1'b1;
        d = rob_q[j].val;
      end
  endfunction

  // One clock edge. The model consumes the inputs the DUT saw at the edge, and the
  // task returns 1 time unit after the edge.
  task automatic tick();
    bit   full_pre, do_commit;
    int   idx;
    ent_t e;
    @(posedge clk);
    if (flush) begin
      rob_q.delete();
      next_tag = 0;
      exp_rbus = 4'hF;
      exp_cv   = 1'b0;
    end else begin
      exp_rbus  = 4'h0;
      full_pre  = rob_q.size() >= RBS;
      do_commit = rob_q.size() > 0 && rob_q[0].done;
      for (int i = 0; i < FUN; i++) begin
        if (valid_bus[i]) begin
          idx = find_pending(int'(RB_index_bus[i*RBI +: RBI]));
          if (idx >= 0) begin
            rob_q[idx].done = 1'b1;
            rob_q[idx].val  = data_bus[i*WS +: WS];
          end
        end
      end
      if (do_commit) begin
        e = rob_q.pop_front();
        if (e.dest != 5'd0) rf_m[e.dest] = e.val;
        exp_cv    = 1'b1;
        exp_creg  = e.dest;
        exp_cdata = e.val;
      end else begin
        exp_cv = 1'b0;
      end
      if (alloc_req && !full_pre) begin
        e.tag  = next_tag;
        e.dest = alloc_dest;
        e.done = 1'b0;
        e.val  = '0;
        rob_q.push_back(e);
        next_tag = (next_tag + 1) % RBS;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    flush        = 1'b0;
    alloc_req    = 1'b0;
    alloc_dest   = '0;
    valid_bus    = '0;
    data_bus     = '0;
    RB_index_bus = '0;
  endtask

  task automatic fu_write(input int fu, input logic [3:0] tag, input logic [31:0] d);
    valid_bus[fu]              = 1'b1;
    RB_index_bus[fu*RBI +: RBI] = tag;
    data_bus[fu*WS +: WS]       = d;
  endtask

  task automatic test_reset();
    model_reset();
    #12;
    vectors++;
    if (reset_bus !== 4'hF) begin miscompares++; $display("FAIL reset_bus_in_reset: got %h want f", reset_bus); end
    vectors++;
    if (alloc_ok !== 1'b1 || alloc_index !== 4'd0) begin
      miscompares++; $display("FAIL reset_alloc: got ok=%b idx=%0d want ok=1 idx=0", alloc_ok, alloc_index);
    end
    vectors++;
    if (CDB_data_valid !== '0 || CDB_data_data !== '0 || commit_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_outputs: cdb_v=%h cv=%b want 0", CDB_data_valid, commit_valid);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    vectors++;
    if (reset_bus !== 4'hF) begin miscompares++; $display("FAIL reset_bus_held: got %h want f", reset_bus); end
    tick();
    vectors++;
    if (reset_bus !== 4'h0) begin miscompares++; $display("FAIL reset_bus_release: got %h want 0", reset_bus); end
  endtask

  task automatic test_basic();
    alloc_req = 1'b1; alloc_dest = 5'd3; reg_numj = 5'd3;
    tick();
    idle_inputs();
    fu_write(1, 4'd0, 32'd7);
    #1;
    vectors++;
    if (vj !== 32'd0 || qj !== 4'd0) begin miscompares++; $display("FAIL basic_pending_lookup: got (%0h,%0d) want (0,0)", vj, qj); end
    tick();
    idle_inputs();
    vectors++;
    if (CDB_data_valid[0] !== 1'b1 || CDB_data_data[31:0] !== 32'd7) begin
      miscompares++; $display("FAIL basic_cdb: got v=%b d=%0h want v=1 d=7", CDB_data_valid[0], CDB_data_data[31:0]);
    end
    vectors++;
    if (vj !== 32'd7 || qj !== T_READY) begin miscompares++; $display("FAIL basic_forward: got (%0h,%0d) want (7,14)", vj, qj); end
    tick();
    vectors++;
    if (commit_valid !== 1'b1 || commit_reg !== 5'd3 || commit_data !== 32'd7) begin
      miscompares++; $display("FAIL basic_commit: got v=%b r=%0d d=%0h want 1/3/7", commit_valid, commit_reg, commit_data);
    end
    vectors++;
    if (CDB_data_valid[0] !== 1'b0 || vj !== 32'd7 || qj !== T_READY) begin
      miscompares++; $display("FAIL basic_after_commit: got cdb=%b (%0h,%0d) want 0 (7,14)", CDB_data_valid[0], vj, qj);
    end
    tick();
    vectors++;
    if (commit_valid !== 1'b0) begin miscompares++; $display("FAIL basic_commit_pulse: got %b want 0", commit_valid); end
  endtask

  task automatic test_async_reset();
    alloc_req = 1'b1; alloc_dest = 5'd2;
    tick();
    idle_inputs();
    fu_write(0, 4'd1, 32'hAB);
    tick();
    idle_inputs();
    vectors++;
    if (CDB_data_valid[1] !== 1'b1) begin miscompares++; $display("FAIL areset_pre: got cdb1=%b want 1", CDB_data_valid[1]); end
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (CDB_data_valid !== '0 || CDB_data_data !== '0 || reset_bus !== 4'hF) begin
      miscompares++; $display("FAIL areset_immediate: cdb_v=%h rbus=%h want 0/f", CDB_data_valid, reset_bus);
    end
    vectors++;
    if (alloc_ok !== 1'b1 || alloc_index !== 4'd0 || vj !== 32'd0 || qj !== T_READY) begin
      miscompares++; $display("FAIL areset_state: ok=%b idx=%0d r3=(%0h,%0d) want 1/0/(0,14)", alloc_ok, alloc_index, vj, qj);
    end
    #1;
    reset_n = 1'b1;
    tick();
    vectors++;
    if (reset_bus !== 4'h0) begin miscompares++; $display("FAIL areset_release: got %h want 0", reset_bus); end
  endtask

  task automatic test_full_wrap();
    for (int n = 0; n < RBS; n++) begin
      alloc_req = 1'b1; alloc_dest = 5'(n + 1);
      #1;
      vectors++;
      if (alloc_ok !== 1'b1 || alloc_index !== 4'(n)) begin
        miscompares++; $display("FAIL fill_%0d: got ok=%b idx=%0d want ok=1 idx=%0d", n, alloc_ok, alloc_index, n);
      end
      tick();
    end
    vectors++;
    if (alloc_ok !== 1'b0 || alloc_index !== 4'd0) begin
      miscompares++; $display("FAIL full: got ok=%b idx=%0d want ok=0 idx=0", alloc_ok, alloc_index);
    end
    alloc_req = 1'b1; alloc_dest = 5'd9; reg_numj = 5'd9;
    tick();
    idle_inputs();
    vectors++;
    if (alloc_ok !== 1'b0 || qj !== T_READY) begin
      miscompares++; $display("FAIL full_ignored: got ok=%b q9=%0d want ok=0 q9=14", alloc_ok, qj);
    end
  endtask

  task automatic test_same_tag();
    fu_write(0, 4'd2, 32'd5);
    fu_write(2, 4'd2, 32'd9);
    reg_numk = 5'd3;
    tick();
    idle_inputs();
    vectors++;
    if (CDB_data_valid[2] !== 1'b1 || CDB_data_data[2*WS +: WS] !== 32'd5) begin
      miscompares++; $display("FAIL same_tag: got v=%b d=%0h want v=1 d=5", CDB_data_valid[2], CDB_data_data[2*WS +: WS]);
    end
    vectors++;
    if (vk !== 32'd5 || qk !== T_READY) begin miscompares++; $display("FAIL same_tag_lookup: got (%0h,%0d) want (5,14)", vk, qk); end
    fu_write(1, 4'd2, 32'h77);
    fu_write(3, 4'd0, 32'h33);
    tick();
    idle_inputs();
    vectors++;
    if (CDB_data_data[2*WS +: WS] !== 32'd5 || CDB_data_valid[0] !== 1'b1) begin
      miscompares++; $display("FAIL done_write_dropped: got d2=%0h v0=%b want 5/1", CDB_data_data[2*WS +: WS], CDB_data_valid[0]);
    end
    tick();
    vectors++;
    if (commit_valid !== 1'b1 || commit_reg !== 5'd1 || commit_data !== 32'h33 || alloc_ok !== 1'b1 || alloc_index !== 4'd0) begin
      miscompares++; $display("FAIL wrap_commit: got v=%b r=%0d d=%0h ok=%b idx=%0d want 1/1/33/1/0",
                              commit_valid, commit_reg, commit_data, alloc_ok, alloc_index);
    end
  endtask

  task automatic test_flush();
    flush = 1'b1; reg_numj = 5'd1; reg_numk = 5'd4;
    tick();
    idle_inputs();
    vectors++;
    if (reset_bus !== 4'hF || CDB_data_valid !== '0 || alloc_ok !== 1'b1 || alloc_index !== 4'd0) begin
      miscompares++; $display("FAIL flush_state: rbus=%h cdb=%h ok=%b idx=%0d want f/0/1/0", reset_bus, CDB_data_valid, alloc_ok, alloc_index);
    end
    vectors++;
    if (vj !== 32'h33 || qj !== T_READY || vk !== 32'd0 || qk !== T_READY) begin
      miscompares++; $display("FAIL flush_regs: r1=(%0h,%0d) r4=(%0h,%0d) want (33,14) (0,14)", vj, qj, vk, qk);
    end
    tick();
    vectors++;
    if (reset_bus !== 4'h0) begin miscompares++; $display("FAIL flush_pulse: got %h want 0", reset_bus); end
  endtask

  task automatic test_rename_shadow();
    alloc_req = 1'b1; alloc_dest = 5'd4; reg_numj = 5'd4;
    tick();
    tick();
    idle_inputs();
    fu_write(2, 4'd0, 32'h44);
    tick();
    idle_inputs();
    tick();
    vectors++;
    if (commit_valid !== 1'b1 || commit_reg !== 5'd4 || commit_data !== 32'h44) begin
      miscompares++; $display("FAIL shadow_commit: got v=%b r=%0d d=%0h want 1/4/44", commit_valid, commit_reg, commit_data);
    end
    vectors++;
    if (vj !== 32'd0 || qj !== 4'd1) begin miscompares++; $display("FAIL shadow_lookup: got (%0h,%0d) want (0,1)", vj, qj); end
    fu_write(0, 4'd1, 32'h55);
    tick();
    idle_inputs();
    tick();
    vectors++;
    if (vj !== 32'h55 || qj !== T_READY) begin miscompares++; $display("FAIL shadow_final: got (%0h,%0d) want (55,14)", vj, qj); end
  endtask

  task automatic test_random();
    logic [31:0] ev;
    logic [3:0]  eq;
    bit          cv;
    logic [31:0] cd;
    int          r;
    for (int n = 0; n < 600; n++) begin
      flush      = ($urandom_range(0, 39) == 0);
      alloc_req  = 1'($urandom_range(0, 1));
      alloc_dest = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      valid_bus  = 4'($urandom);
      for (int i = 0; i < FUN; i++) begin
        r = $urandom_range(0, 9);
        RB_index_bus[i*RBI +: RBI] = (r < 8) ? 4'(r) : ((r == 8) ? T_READY : T_NULL);
        data_bus[i*WS +: WS]       = $urandom;
      end
      reg_numj = 5'($urandom_range(0, 8));
      reg_numk = 5'($urandom_range(0, 31));
      #1;
      vectors++;
      if (alloc_ok !== (rob_q.size() < RBS) || alloc_index !== 4'(next_tag)) begin
        miscompares++; $display("FAIL rand_alloc@%0d: got ok=%b idx=%0d want ok=%b idx=%0d",
                                n, alloc_ok, alloc_index, rob_q.size() < RBS, next_tag);
      end
      exp_lookup(reg_numj, ev, eq);
      vectors++;
      if (vj !== ev || qj !== eq) begin
        miscompares++; $display("FAIL rand_lookup_j@%0d r%0d: got (%0h,%0d) want (%0h,%0d)", n, reg_numj, vj, qj, ev, eq);
      end
      exp_lookup(reg_numk, ev, eq);
      vectors++;
      if (vk !== ev || qk !== eq) begin
        miscompares++; $display("FAIL rand_lookup_k@%0d r%0d: got (%0h,%0d) want (%0h,%0d)", n, reg_numk, vk, qk, ev, eq);
      end
      tick();
      vectors++;
      if (reset_bus !== exp_rbus || commit_valid !== exp_cv) begin
        miscompares++; $display("FAIL rand_ctrl@%0d: got rbus=%h cv=%b want rbus=%h cv=%b", n, reset_bus, commit_valid, exp_rbus, exp_cv);
      end
      if (exp_cv) begin
        vectors++;
        if (commit_reg !== exp_creg || commit_data !== exp_cdata) begin
          miscompares++; $display("FAIL rand_commit@%0d: got r=%0d d=%0h want r=%0d d=%0h", n, commit_reg, commit_data, exp_creg, exp_cdata);
        end
      end
      for (int k = 0; k < RBS; k++) begin
        exp_cdb(k, cv, cd);
        vectors++;
        if (CDB_data_valid[k] !== cv || (cv && CDB_data_data[k*WS +: WS] !== cd)) begin
          miscompares++; $display("FAIL rand_cdb@%0d e%0d: got v=%b d=%0h want v=%b d=%0h",
                                  n, k, CDB_data_valid[k], CDB_data_data[k*WS +: WS], cv, cd);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_async_reset();
    test_full_wrap();
    test_same_tag();
    test_flush();
    test_rename_shadow();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
